// File: rtl/four_connect_pkg.sv
// Shared sizes, cell encoding and board type for the Connect Four core.
// board_to_frame fixes the LED frame bit order used by the serializer.
package four_connect_pkg;

    localparam int NUM_COLS   = 7;
    localparam int NUM_ROWS   = 6;
    localparam int FRAME_BITS = 84;
    localparam int COL_W      = 3;
    localparam int HGT_W      = 3;
    localparam int CNT_W      = 7;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef logic [NUM_ROWS-1:0][1:0] column_t;
    typedef column_t [NUM_COLS-1:0]   board_t;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

    // Column-major, bottom row first, cell bit1 ahead of bit0; frame bit 0 leaves first.
    function automatic logic [FRAME_BITS-1:0] board_to_frame(input board_t b);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                f[(c*NUM_ROWS + r)*2]     = b[c][r][1];
                f[(c*NUM_ROWS + r)*2 + 1] = b[c][r][0];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/four_connect_if.sv
// Pin-level bundle between the button/LED pads and the Connect Four core.
interface four_connect_if;
    import four_connect_pkg::*;

    logic [NUM_COLS-1:0] pins;
    logic [COL_W-1:0]    col;
    logic                ready;
    logic                led;

    modport master (output pins, input col, input ready, input led);
    modport slave  (input pins, output col, output ready, output led);

endinterface

// File: rtl/four_connect_serializer.sv
// Snapshots the board and shifts it out on led, one bit per clock.
// ack pulses on every edge that loads a new frame, including back-to-back reloads.
module four_connect_serializer
    import four_connect_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  board_t board,
    input  logic   req,
    output logic   ack,
    output logic   ready,
    output logic   led
);

    ser_state_t            state, state_n;
    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      cnt;
    logic                  last;

    assign last = (cnt == CNT_W'(FRAME_BITS - 1));

    always_comb begin
        state_n = state;
        ack     = 1'b0;
        case (state)
            SER_IDLE: begin
                if (req) begin
                    ack     = 1'b1;
                    state_n = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (last) begin
                    if (req) ack = 1'b1;
                    else     state_n = SER_IDLE;
                end
            end
            default: state_n = SER_IDLE;
        endcase
    end

    // After the final shift the register has emptied, so led falls to 0 with ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SER_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (ack) begin
                shreg <= board_to_frame(board);
                cnt   <= '0;
            end else if (state == SER_SHIFT) begin
                shreg <= shreg >> 1;
                cnt   <= last ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    assign ready = (state == SER_IDLE);
    assign led   = shreg[0];

endmodule

// File: rtl/four_connect.sv
// Connect Four core: button priority encoder, press edge detect, board/heights/player,
// and a frame request towards the serializer.
module four_connect
    import four_connect_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    four_connect_if.slave bus
);

    logic [COL_W-1:0]                col_c, col_q;
    logic [COL_W-1:0]                idx;
    logic                            press, full, drop;
    logic                            player;
    logic                            frame_req, ack;
    board_t                          board;
    logic [NUM_COLS-1:0][HGT_W-1:0]  height;

    // Descending scan so the lowest set bit is the last to assign.
    always_comb begin
        col_c = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (bus.pins[i]) col_c = COL_W'(i + 1);
        end
    end

    assign bus.col = col_c;
    assign idx     = (col_c == '0) ? '0 : col_c - COL_W'(1);
    assign press   = (col_c != '0) && (col_q == '0);
    assign full    = (height[idx] == HGT_W'(NUM_ROWS));
    assign drop    = press && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            board     <= '0;
            height    <= '0;
            player    <= 1'b0;
            frame_req <= 1'b0;
        end else begin
            col_q     <= col_c;
            // A drop on the same edge as a load re-arms the request for the next frame.
            frame_req <= drop | (frame_req & ~ack);
            if (drop) begin
                board[idx][height[idx]] <= player ? CELL_P2 : CELL_P1;
                height[idx]             <= height[idx] + HGT_W'(1);
                player                  <= ~player;
            end
        end
    end

    four_connect_serializer u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .board (board),
        .req   (frame_req),
        .ack   (ack),
        .ready (bus.ready),
        .led   (bus.led)
    );

endmodule

// File: tb/tb_four_connect.sv
// Directed and randomized bench for four_connect against a simple board model.
module tb_four_connect;
    import four_connect_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    four_connect_if bus();

    four_connect dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mb[7][6];
    int mh[7];
    int mp;

    task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 7; c++) begin
            mh[c] = 0;
            for (int r = 0; r < 6; r++) mb[c][r] = 0;
        end
        mp = 1;
    endfunction

    function automatic int pick_col(input logic [6:0] v);
        for (int i = 0; i < 7; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    function automatic bit model_press(input int c);
        if (c == 0 || mh[c-1] >= 6) return 1'b0;
        mb[c-1][mh[c-1]] = mp;
        mh[c-1]++;
        mp = 3 - mp;
        return 1'b1;
    endfunction

    function automatic logic [83:0] model_frame();
        logic [83:0] f;
        int k;
        f = '0;
        k = 0;
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                f[k]   = mb[c][r][1];
                f[k+1] = mb[c][r][0];
                k += 2;
            end
        end
        return f;
    endfunction

    // Pins v held for hold edges, then v2 for hold2 edges, then released; checks one frame window.
    task automatic press(input logic [6:0] v, input int hold, input logic [6:0] v2,
                         input int hold2, output logic [83:0] got);
        bit          drop, rdy_ok;
        logic [83:0] exp;
        int          c;
        c = pick_col(v);
        bus.pins = v;
        #1;
        chk("col", 84'(bus.col), 84'(c));
        @(posedge clk); #1;
        drop   = model_press(c);
        exp    = drop ? model_frame() : '0;
        got    = '0;
        rdy_ok = 1'b1;
        for (int j = 0; j <= 85; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (j == hold) bus.pins = (hold2 > 0) ? v2 : 7'd0;
            else if (hold2 > 0 && j == hold + hold2) bus.pins = 7'd0;
            if (drop && j >= 1 && j <= 84) begin
                got[j-1] = bus.led;
                if (bus.ready !== 1'b0) rdy_ok = 1'b0;
            end else if (bus.ready !== 1'b1 || bus.led !== 1'b0) rdy_ok = 1'b0;
        end
        chk("frame", got, exp);
        chk("ready_window", 84'(rdy_ok), 84'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 84'(bus.ready), 84'd1);
        chk("rst_led", 84'(bus.led), 84'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [83:0] g, f1, f2, f1e, f2e;
        logic [6:0]  v, v2;
        int          hold, hold2;
        bit          ok;

        rst_n    = 1'b0;
        bus.pins = 7'd0;
        model_reset();
        #1;
        chk("col_none", 84'(bus.col), 84'd0);
        chk("reset_ready", 84'(bus.ready), 84'd1);
        chk("reset_led", 84'(bus.led), 84'd0);
        bus.pins = 7'b0000001; #1; chk("col_b0", 84'(bus.col), 84'd1);
        bus.pins = 7'b0000000; #1; chk("col_zero", 84'(bus.col), 84'd0);
        bus.pins = 7'b0000100; #1; chk("col_b2", 84'(bus.col), 84'd3);
        bus.pins = 7'b0000110; #1; chk("col_prio", 84'(bus.col), 84'd2);
        bus.pins = 7'b1000000; #1; chk("col_b6", 84'(bus.col), 84'd7);
        bus.pins = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // First move: cell (0,0) = P1
        press(7'h01, 1, 7'd0, 0, g);
        chk("first_frame", g, 84'd2);

        do_reset();
        press(7'h04, 1, 7'd0, 0, g);
        press(7'h04, 2, 7'd0, 0, g);
        chk("col3_twice", g, (84'd3 << 25));

        // Fill column 5, seventh press must be ignored
        do_reset();
        for (int i = 0; i < 7; i++) press(7'h10, 1, 7'd0, 0, g);
        press(7'h01, 1, 7'd0, 0, g);
        chk("p1_after_full", 84'(g[1:0]), 84'd2);

        do_reset();
        press(7'h01, 20, 7'h04, 10, g);
        chk("hold_switch", g, 84'd2);

        // Press mid-frame: back-to-back second frame, ready low throughout
        do_reset();
        bus.pins = 7'h02;
        @(posedge clk); #1;
        void'(model_press(2));
        f1e = model_frame();
        f2e = '0;
        bus.pins = 7'd0;
        ok = 1'b1;
        f1 = '0;
        f2 = '0;
        for (int j = 1; j <= 169; j++) begin
            @(posedge clk); #1;
            if (j == 40) bus.pins = 7'h08;
            if (j == 41) begin
                bus.pins = 7'd0;
                void'(model_press(4));
                f2e = model_frame();
            end
            if (j <= 84) f1[j-1] = bus.led;
            else if (j <= 168) f2[j-85] = bus.led;
            if (j <= 168 && bus.ready !== 1'b0) ok = 1'b0;
            if (j == 169 && (bus.ready !== 1'b1 || bus.led !== 1'b0)) ok = 1'b0;
        end
        chk("b2b_frame1", f1, f1e);
        chk("b2b_frame2", f2, f2e);
        chk("b2b_ready", 84'(ok), 84'd1);

        // Reset in the middle of a frame
        bus.pins = 7'h20;
        @(posedge clk); #1;
        void'(model_press(6));
        bus.pins = 7'd0;
        repeat (30) @(posedge clk);
        #3;
        chk("busy_before_rst", 84'(bus.ready), 84'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 84'(bus.ready), 84'd1);
        chk("midrst_led", 84'(bus.led), 84'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        ok = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            if (bus.ready !== 1'b1 || bus.led !== 1'b0) ok = 1'b0;
        end
        chk("no_pending_after_rst", 84'(ok), 84'd1);
        press(7'h01, 1, 7'd0, 0, g);
        chk("empty_after_rst", g, 84'd2);

        // Randomized moves against the model
        do_reset();
        for (int n = 0; n < 80; n++) begin
            if (n == 40) do_reset();
            if ($urandom_range(0, 1) == 1) v = 7'(7'd1 << $urandom_range(0, 6));
            else                           v = 7'($urandom_range(1, 127));
            hold  = $urandom_range(1, 5);
            hold2 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
            v2    = 7'($urandom_range(1, 127));
            press(v, hold, v2, hold2, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
